riscv_instr_mem_responder: RTL and testbench

//  Memory-side responder for the core instruction-fetch bus (req/gnt address phase, rvalid/rdata/err response phase).

---
 rtl/riscv_instr_resp_pkg.sv | 23 ++
 rtl/riscv_instr_resp_pipe.sv | 40 ++++
 rtl/riscv_instr_mem_responder.sv | 138 +++++++++++++
 tb/tb_riscv_instr_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_instr_resp_pkg.sv
// Shared types and constants for the instruction-fetch memory responder:
// response record carried through the delay line and the stall LFSR definition.
package riscv_instr_resp_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } instr_resp_t;

    localparam int unsigned MAX_LATENCY = 8;

    localparam int unsigned LFSR_WIDTH  = 16;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    localparam instr_resp_t RESP_IDLE = {1'b0, 1'b0, 32'h0000_0000};

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] state);
        return {state[LFSR_WIDTH-2:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/riscv_instr_resp_pipe.sv
// Fixed-depth delay line for fetch responses; stage 0 is the array read register.
// A synchronous reset empties every stage so in-flight responses are dropped.
module riscv_instr_resp_pipe
    import riscv_instr_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$bits(instr_resp_t)-1:0]  resp_i,
    output logic [$bits(instr_resp_t)-1:0]  resp_o
);

    instr_resp_t stage_q [DEPTH];
    instr_resp_t stage_d [DEPTH];

    // Shift: new response enters stage 0, every other stage takes its predecessor.
    always_comb begin
        stage_d[0] = instr_resp_t'(resp_i);
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= RESP_IDLE;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch memory responder: word SRAM, address decode, outstanding counter
// and fixed-latency in-order responses. Optional grant stalling via INSTR_RESP_STALL_EN.
module riscv_instr_mem_responder
    import riscv_instr_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                  load_wdata_i,
    output logic                         busy_o
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam int unsigned CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned RESP_W   = $bits(instr_resp_t);
    localparam logic [32:0] MEM_SPAN = 33'(MEM_WORDS) << 2;

    logic [31:0]       mem_q [MEM_WORDS];
    logic [31:0]       off_s;
    logic              addr_err_s;
    logic [AW-1:0]     idx_s;
    logic              stall_s;
    logic              gnt_s;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              busy_q;
    logic              busy_d;
    instr_resp_t       resp_in_s;
    instr_resp_t       resp_out_s;
    logic [RESP_W-1:0] pipe_out_s;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR fall out of range.
    always_comb begin
        off_s      = instr_addr_i - BASE_ADDR;
        addr_err_s = ({1'b0, off_s} >= MEM_SPAN) || (off_s[1:0] != 2'b00);
        idx_s      = off_s[AW+1:2];
    end

`ifdef INSTR_RESP_STALL_EN
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;

    // Stall pattern generator: advances every cycle, denies grant when low bits are zero.
    always_comb begin
        lfsr_d  = lfsr_next(lfsr_q);
        stall_s = (lfsr_q[1:0] == 2'b00);
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic seed_unused_s;

    // No stalling: grant depends only on request and occupancy.
    always_comb begin
        stall_s       = 1'b0;
        seed_unused_s = ^STALL_SEED;
    end
`endif

    // Grant uses the registered count only; a same-cycle rvalid does not free a slot.
    always_comb begin
        gnt_s = instr_req_i & (cnt_q < CW'(MAX_OUTSTANDING)) & ~stall_s & ~rst;
    end

    // Build the response for an accepted request; array read happens in the accept cycle.
    always_comb begin
        resp_in_s = RESP_IDLE;
        if (gnt_s) begin
            resp_in_s.valid = 1'b1;
            resp_in_s.err   = addr_err_s;
            resp_in_s.rdata = addr_err_s ? 32'h0000_0000 : mem_q[idx_s];
        end else begin
            resp_in_s = RESP_IDLE;
        end
    end

    riscv_instr_resp_pipe #(
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .resp_i (resp_in_s),
        .resp_o (pipe_out_s)
    );

    assign resp_out_s = instr_resp_t'(pipe_out_s);

    // Occupancy bookkeeping: one in per accept, one out per response.
    always_comb begin
        cnt_d  = cnt_q + CW'(gnt_s) - CW'(resp_out_s.valid);
        busy_d = (cnt_d != {CW{1'b0}});
    end

    // Counter and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Backdoor write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    assign instr_gnt_o    = gnt_s;
    assign instr_rvalid_o = resp_out_s.valid;
    assign instr_err_o    = resp_out_s.err;
    assign instr_rdata_o  = resp_out_s.rdata;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Self-checking bench for riscv_instr_mem_responder: fixed vector table plus
// randomized traffic compared against a queue-based reference model.
module tb_riscv_instr_mem_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          LAT  = 3;
    localparam int          MAXO = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst, req, gnt, rvalid, err, we, busy;
    logic [31:0] addr, rdata, wdata;
    logic [5:0]  widx;

    always #5 clk = ~clk;

    riscv_instr_mem_responder #(
        .MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT),
        .MAX_OUTSTANDING(MAXO), .STALL_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt),
        .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
        .load_we_i(we), .load_addr_i(widx), .load_wdata_i(wdata),
        .busy_o(busy)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [5:0]  widx;
        logic [31:0] wdata;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    exp_t        q[$];
    logic [31:0] ref_mem [MW];
    logic [15:0] ref_lfsr = SEED;
    int          cyc = 0;
    bit          primed = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        e_gnt, e_rv;
    vec_t        tv [20];

    function automatic vec_t mk(logic rq, logic [31:0] a, logic w, logic [5:0] wi, logic [31:0] wd,
                                logic g, logic rv, logic er, logic [31:0] rd, logic bz);
        vec_t v;
        v = {rq, a, w, wi, wd, g, rv, er, rd, bz};
        return v;
    endfunction

    function automatic logic [15:0] ref_lfsr_step(logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic [31:0] a,
                         input logic w, input logic [5:0] wi, input logic [31:0] wd);
        rst = r; req = rq; addr = a; we = w; widx = wi; wdata = wd;
        #2;
    endtask

    // Reference decode from the address rules: offset with wrap, range and alignment.
    task automatic model_check();
        logic stall;
        stall = 1'b0;
`ifdef INSTR_RESP_STALL_EN
        stall = (ref_lfsr[1:0] == 2'b00);
`endif
        e_gnt = !rst && req && (q.size() < MAXO) && !stall;
        e_rv  = (q.size() > 0) && (q[0].due == cyc);
        if (primed) begin
            chk("gnt", {31'd0, gnt}, {31'd0, e_gnt});
            chk("rvalid", {31'd0, rvalid}, {31'd0, e_rv});
            chk("err", {31'd0, err}, e_rv ? {31'd0, q[0].err} : 32'd0);
            chk("rdata", rdata, e_rv ? q[0].data : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
        end
    endtask

    task automatic model_advance();
        logic [31:0] off;
        exp_t        e;
        if (rst) begin
            q.delete();
            ref_lfsr = SEED;
            primed   = 1'b1;
        end else begin
            if (e_rv) void'(q.pop_front());
            if (e_gnt) begin
                off    = addr - BASE;
                e.due  = cyc + LAT;
                e.err  = (off >= MW * 4) || (addr[1:0] != 2'b00);
                e.data = e.err ? 32'd0 : ref_mem[off >> 2];
                q.push_back(e);
            end
            ref_lfsr = ref_lfsr_step(ref_lfsr);
        end
        if (we) ref_mem[widx] = wdata;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic r, input logic rq, input logic [31:0] a,
                        input logic w, input logic [5:0] wi, input logic [31:0] wd);
        drive(r, rq, a, w, wi, wd);
        model_check();
        model_advance();
    endtask

    initial begin
        // Hand-derived cycle table for LATENCY=3, MAX_OUTSTANDING=2, mem[i]=0x11*(i+1).
        tv[0]  = mk(1, 32'h1000, 0, 6'd0, 32'd0, 1, 0, 0, 32'h0, 0);
        tv[1]  = mk(1, 32'h1004, 0, 6'd0, 32'd0, 1, 0, 0, 32'h0, 1);
        tv[2]  = mk(1, 32'h1008, 0, 6'd0, 32'd0, 0, 0, 0, 32'h0, 1);
        tv[3]  = mk(1, 32'h1008, 0, 6'd0, 32'd0, 0, 1, 0, 32'h11, 1);
        tv[4]  = mk(1, 32'h1008, 0, 6'd0, 32'd0, 1, 1, 0, 32'h22, 1);
        tv[5]  = mk(1, 32'h0FFC, 0, 6'd0, 32'd0, 1, 0, 0, 32'h0, 1);
        tv[6]  = mk(1, 32'h1002, 0, 6'd0, 32'd0, 0, 0, 0, 32'h0, 1);
        tv[7]  = mk(1, 32'h1002, 0, 6'd0, 32'd0, 0, 1, 0, 32'h33, 1);
        tv[8]  = mk(1, 32'h1002, 0, 6'd0, 32'd0, 1, 1, 1, 32'h0, 1);
        tv[9]  = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 0, 0, 32'h0, 1);
        tv[10] = mk(1, 32'h1100, 0, 6'd0, 32'd0, 1, 0, 0, 32'h0, 1);
        tv[11] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 1, 1, 32'h0, 1);
        tv[12] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 0, 0, 32'h0, 1);
        tv[13] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 1, 1, 32'h0, 1);
        tv[14] = mk(1, 32'h1014, 1, 6'd5, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 0);
        tv[15] = mk(1, 32'h1014, 0, 6'd0, 32'd0, 1, 0, 0, 32'h0, 1);
        tv[16] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 0, 0, 32'h0, 1);
        tv[17] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 1, 0, 32'h66, 1);
        tv[18] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 1, 0, 32'hDEAD_BEEF, 1);
        tv[19] = mk(0, 32'h0000, 0, 6'd0, 32'd0, 0, 0, 0, 32'h0, 0);

        step(1, 0, 32'd0, 0, 6'd0, 32'd0);
        step(1, 0, 32'd0, 0, 6'd0, 32'd0);
        for (int i = 0; i < MW; i++) begin
            step(0, 0, 32'd0, 1, 6'(i), 32'h11 * (i + 1));
        end
        step(0, 0, 32'd0, 0, 6'd0, 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(0, tv[i].req, tv[i].addr, tv[i].we, tv[i].widx, tv[i].wdata);
            model_check();
`ifndef INSTR_RESP_STALL_EN
            chk($sformatf("tbl_gnt[%0d]", i), {31'd0, gnt}, {31'd0, tv[i].gnt});
            chk($sformatf("tbl_rvalid[%0d]", i), {31'd0, rvalid}, {31'd0, tv[i].rv});
            chk($sformatf("tbl_err[%0d]", i), {31'd0, err}, {31'd0, tv[i].err});
            chk($sformatf("tbl_rdata[%0d]", i), rdata, tv[i].rdata);
            chk($sformatf("tbl_busy[%0d]", i), {31'd0, busy}, {31'd0, tv[i].busy});
`endif
            model_advance();
        end

        // Reset with responses in flight, then refetch to show the array survived.
        step(0, 1, BASE + 32'h8, 0, 6'd0, 32'd0);
        step(0, 1, BASE + 32'hC, 0, 6'd0, 32'd0);
        step(1, 1, BASE + 32'h8, 0, 6'd0, 32'd0);
        step(1, 1, BASE + 32'h8, 0, 6'd0, 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 0, 6'd0, 32'd0);
        step(0, 1, BASE + 32'h8, 0, 6'd0, 32'd0);
        step(0, 1, BASE + 32'hC, 0, 6'd0, 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 0, 6'd0, 32'd0);

        // Randomized traffic; the middle stretch holds req high continuously.
        for (int i = 0; i < 1500; i++) begin
            logic        r, rq, w;
            logic [31:0] a;
            int          sel;
            r   = ($urandom_range(0, 199) == 0);
            rq  = (i >= 400 && i < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 19);
            if (sel < 16)       a = BASE + 32'($urandom_range(0, MW - 1)) * 32'd4;
            else if (sel == 16) a = BASE + 32'($urandom_range(0, MW - 1)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (sel == 17) a = BASE + 32'(MW * 4) + 32'($urandom_range(0, 15)) * 32'd4;
            else if (sel == 18) a = BASE - 32'd4;
            else                a = $urandom;
            w = ($urandom_range(0, 9) == 0);
            step(r, rq, a, w, 6'($urandom_range(0, MW - 1)), $urandom);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 32'd0, 0, 6'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
